// File: rtl/fpu_result_collector.sv
// ---------------------------------------------------------------------------
// fpu_result_collector
//
// Sits downstream of the FPU operand demux. It captures the result and the
// exception flags of the unit chosen at issue time, registers them, and hands
// exactly one result to the consumer over a valid/ready handshake. The issuer
// is throttled through issue_ready so that at most one operation is in flight.
//
// The addsub and mul units are combinational, so their outputs are sampled in
// the issue cycle itself. The divsqrt unit has variable latency and announces
// its result with a one-cycle div_out_valid pulse. A watchdog bounds the time
// spent waiting for it; when it expires a canonical invalid result is produced
// and the sticky timeout flag is raised.
//
// Ports
//   clk             in   1            rising-edge clock
//   rst_n           in   1            synchronous active-low reset
//   start           in   1            issue strobe, honoured only when issue_ready=1
//   control_signal  in   2            op select: 00 addsub, 01 mul, 10 divsqrt, 11 invalid
//   add_out         in   DATA_WIDTH+1 addsub recoded result
//   add_flags       in   5            addsub flags {invalid,infinite,overflow,underflow,inexact}
//   mul_out         in   DATA_WIDTH+1 mul recoded result
//   mul_flags       in   5            mul flags
//   div_out         in   DATA_WIDTH+1 divsqrt recoded result
//   div_flags       in   5            divsqrt flags
//   div_out_valid   in   1            divsqrt result strobe (single-cycle pulse)
//   result          out  DATA_WIDTH+1 registered result
//   flags           out  5            registered exception flags
//   result_valid    out  1            result/flags are valid
//   result_ready    in   1            consumer takes the result this cycle
//   issue_ready     out  1            a start is accepted this cycle
//   timeout         out  1            sticky: the divsqrt watchdog fired
// ---------------------------------------------------------------------------
module fpu_result_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            control_signal,
  input  logic [DATA_WIDTH:0]   add_out,
  input  logic [4:0]            add_flags,
  input  logic [DATA_WIDTH:0]   mul_out,
  input  logic [4:0]            mul_flags,
  input  logic [DATA_WIDTH:0]   div_out,
  input  logic [4:0]            div_flags,
  input  logic                  div_out_valid,
  output logic [DATA_WIDTH:0]   result,
  output logic [4:0]            flags,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  issue_ready,
  output logic                  timeout
);

  // Counter wide enough to hold DIV_TIMEOUT-1, the last cycle we are willing
  // to wait for the divider.
  localparam int CNT_W = $clog2(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  // Flag pattern used for both the invalid opcode and the watchdog abort:
  // only the "invalid" exception bit is set.
  localparam logic [4:0] FLAGS_INVALID = 5'b10000;

  localparam logic [1:0] OP_ADDSUB  = 2'b00;
  localparam logic [1:0] OP_MUL     = 2'b01;
  localparam logic [1:0] OP_DIVSQRT = 2'b10;

  // A watchdog that expires in its first wait cycle would make the divider
  // unusable, so reject such configurations at elaboration.
  if (DIV_TIMEOUT < 2) begin : g_bad_timeout
    $error("fpu_result_collector: DIV_TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_DIV = 2'b01,
    DONE     = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH:0]   result_q, result_d;
  logic [4:0]            flags_q, flags_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  accept;
  logic                  div_expired;

  assign accept      = start && issue_ready;
  assign div_expired = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An accept taken in DONE (back-to-back issue) follows
  // exactly the same path as an accept taken in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (control_signal == OP_DIVSQRT) begin
            state_d = WAIT_DIV;
          end else begin
            state_d = DONE;
          end
        end else if (state_q == DONE && result_ready) begin
          state_d = IDLE;
        end
      end
      WAIT_DIV: begin
        if (div_out_valid || div_expired) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state. issue_ready also looks at result_ready so
  // the consumer draining a result frees the slot for a same-cycle issue.
  always_comb begin
    result_valid = (state_q == DONE);
    issue_ready  = (state_q == IDLE) || ((state_q == DONE) && result_ready);
  end

  // Datapath next values. Capture happens either at accept time (combinational
  // units and the invalid opcode) or while waiting on the divider. A divider
  // strobe arriving in the same cycle as watchdog expiry takes priority, so a
  // late-but-legal result is never thrown away.
  always_comb begin
    result_d  = result_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    if (accept) begin
      unique case (control_signal)
        OP_ADDSUB: begin
          result_d = add_out;
          flags_d  = add_flags;
        end
        OP_MUL: begin
          result_d = mul_out;
          flags_d  = mul_flags;
        end
        OP_DIVSQRT: begin
          cnt_d = '0;
        end
        default: begin
          result_d = '0;
          flags_d  = FLAGS_INVALID;
        end
      endcase
    end else if (state_q == WAIT_DIV) begin
      if (div_out_valid) begin
        result_d = div_out;
        flags_d  = div_flags;
      end else if (div_expired) begin
        result_d  = '0;
        flags_d   = FLAGS_INVALID;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers. timeout is only ever cleared here by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      flags_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      result_q  <= result_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign result  = result_q;
  assign flags   = flags_q;
  assign timeout = timeout_q;

endmodule
